// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned DEF_REG_AW = 5;

  // EX operand source encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // In-flight destination tracking slot at the default address width
  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [DEF_REG_AW-1:0] wr_addr;
    logic                  is_load;
  } haz_slot_t;

endpackage

// File: rtl/fwd_select.sv
// Priority compare of one EX source address against the MEM and WB slots.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic              src_use_i,
  input  logic              mem_valid_i,
  input  logic              mem_wr_en_i,
  input  logic [REG_AW-1:0] mem_addr_i,
  input  logic              wb_valid_i,
  input  logic              wb_wr_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  output logic [1:0]        fwd_sel_o
);

  // MEM wins over WB; register 0 never forwards
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (src_use_i && (src_addr_i != '0)) begin
      if (mem_valid_i && mem_wr_en_i && (mem_addr_i == src_addr_i)) begin
        fwd_sel_o = FWD_MEM;
      end else if (wb_valid_i && wb_wr_en_i && (wb_addr_i == src_addr_i)) begin
        fwd_sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage pipeline.
// Tracks EX/MEM/WB destinations internally; multiply occupies EX for MUL_LAT cycles.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              ex_br_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned MUL_CNT_W = $clog2(MUL_LAT) + 1;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic              is_load;
  } slot_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
    logic              is_mul;
  } ex_src_t;

  slot_t                ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  ex_src_t              ex_src_q, ex_src_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;

  logic       busy_c;
  logic       load_use_c;
  logic       ex_wr_rs_c, ex_wr_rt_c;
  logic [1:0] fwd_a_raw_c, fwd_b_raw_c;
  logic       unused_slot_bits;

  assign unused_slot_bits = ^{mem_q.is_load, wb_q.is_load};

  // Hazard conditions seen from the current EX slot
  always_comb begin
    busy_c     = ex_q.valid && ex_src_q.is_mul &&
                 (mul_cnt_q < MUL_CNT_W'(MUL_LAT - 1));
    ex_wr_rs_c = ex_q.valid && ex_q.wr_en && (ex_q.wr_addr == id_rs) && (id_rs != '0);
    ex_wr_rt_c = ex_q.valid && ex_q.wr_en && (ex_q.wr_addr == id_rt) && (id_rt != '0);
    load_use_c = ex_q.is_load && id_valid &&
                 ((ex_wr_rs_c && id_use_rs) || (ex_wr_rt_c && id_use_rt));
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_addr_i  (ex_src_q.rs),
    .src_use_i   (ex_src_q.use_rs && ex_q.valid),
    .mem_valid_i (mem_q.valid),
    .mem_wr_en_i (mem_q.wr_en),
    .mem_addr_i  (mem_q.wr_addr),
    .wb_valid_i  (wb_q.valid),
    .wb_wr_en_i  (wb_q.wr_en),
    .wb_addr_i   (wb_q.wr_addr),
    .fwd_sel_o   (fwd_a_raw_c)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_addr_i  (ex_src_q.rt),
    .src_use_i   (ex_src_q.use_rt && ex_q.valid),
    .mem_valid_i (mem_q.valid),
    .mem_wr_en_i (mem_q.wr_en),
    .mem_addr_i  (mem_q.wr_addr),
    .wb_valid_i  (wb_q.valid),
    .wb_wr_en_i  (wb_q.wr_en),
    .wb_addr_i   (wb_q.wr_addr),
    .fwd_sel_o   (fwd_b_raw_c)
  );

  // Priority busy > branch > load-use > normal: control outputs and slot shifting
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    ex_busy      = 1'b0;
    fwd_a        = fwd_a_raw_c;
    fwd_b        = fwd_b_raw_c;
    ex_d         = ex_q;
    ex_src_d     = ex_src_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    mul_cnt_d    = mul_cnt_q;

    if (busy_c) begin
      // Operands were latched on the first EX cycle, so no forwarding now
      ex_busy      = 1'b1;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_bubble = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
      mem_d        = '0;
      wb_d         = mem_q;
      mul_cnt_d    = mul_cnt_q + MUL_CNT_W'(1);
    end else begin
      mem_d     = ex_q;
      wb_d      = mem_q;
      mul_cnt_d = '0;
      if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        ex_d        = '0;
        ex_src_d    = '0;
      end else if (load_use_c) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        ex_d        = '0;
        ex_src_d    = '0;
      end else begin
        ex_d.valid      = id_valid;
        ex_d.wr_en      = id_wr_en;
        ex_d.wr_addr    = id_wr_addr;
        ex_d.is_load    = id_is_load;
        ex_src_d.rs     = id_rs;
        ex_src_d.rt     = id_rt;
        ex_src_d.use_rs = id_use_rs;
        ex_src_d.use_rt = id_use_rt;
        ex_src_d.is_mul = id_is_mul;
      end
    end
  end

  // Shadow slot and multiply counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      ex_src_q  <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mul_cnt_q <= '0;
    end else begin
      ex_q      <= ex_d;
      ex_src_q  <= ex_src_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic             stall_evt_c, flush_evt_c;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  assign stall_evt_c = busy_c || (!ex_br_taken && load_use_c);
  assign flush_evt_c = !busy_c && ex_br_taken;

  // Free-running wrap-around perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt_c) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt_c) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (default parameters, MUL_LAT=4).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_wr_addr;
  logic        id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_mul;
  logic        ex_br_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, ex_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wr_en     (id_wr_en),
    .id_wr_addr   (id_wr_addr),
    .id_is_load   (id_is_load),
    .id_is_mul    (id_is_mul),
    .ex_br_taken  (ex_br_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_bubble (exmem_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .ex_busy      (ex_busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef HAZ_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  // v rs rt use_rs use_rt wr_en wr_addr is_load is_mul
  task automatic set_id(input int v, input int rs, input int rt, input int urs, input int urt,
                        input int we, input int wa, input int ld, input int ml);
    id_valid   = 1'(v);
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_use_rs  = 1'(urs);
    id_use_rt  = 1'(urt);
    id_wr_en   = 1'(we);
    id_wr_addr = 5'(wa);
    id_is_load = 1'(ld);
    id_is_mul  = 1'(ml);
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) adv();
  endtask

  initial begin
    rst = 1'b1;
    ex_br_taken = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    settle();
    check_eq("rst_pc_write",    32'(pc_write), 1);
    check_eq("rst_ifid_write",  32'(ifid_write), 1);
    check_eq("rst_ifid_flush",  32'(ifid_flush), 0);
    check_eq("rst_idex_bubble", 32'(idex_bubble), 0);
    check_eq("rst_exmem_bub",   32'(exmem_bubble), 0);
    check_eq("rst_fwd_a",       32'(fwd_a), 0);
    check_eq("rst_fwd_b",       32'(fwd_b), 0);
    check_eq("rst_ex_busy",     32'(ex_busy), 0);
    check_eq("rst_stall_cnt",   stall_cnt, 0);
    check_eq("rst_flush_cnt",   flush_cnt, 0);
    adv();

    // add $3,$1,$2 ; sub $4,$3,$5 back to back
    set_id(1, 1, 2, 1, 1, 1, 3, 0, 0); settle(); adv();
    set_id(1, 3, 5, 1, 1, 1, 4, 0, 0); settle();
    check_eq("alu_b2b_no_stall", 32'(pc_write), 1);
    adv();
    nop(); settle();
    check_eq("alu_b2b_fwd_a", 32'(fwd_a), 2);
    check_eq("alu_b2b_fwd_b", 32'(fwd_b), 0);
    adv();
    // same pair with one nop between
    set_id(1, 1, 2, 1, 1, 1, 3, 0, 0); settle(); adv();
    nop(); settle(); adv();
    set_id(1, 3, 5, 1, 1, 1, 4, 0, 0); settle();
    check_eq("alu_gap_no_stall", 32'(pc_write), 1);
    adv();
    nop(); settle();
    check_eq("alu_gap_fwd_a", 32'(fwd_a), 1);
    check_eq("alu_gap_fwd_b", 32'(fwd_b), 0);
    drain();

    // lw $2,0($1) ; add $3,$2,$2
    set_id(1, 1, 0, 1, 0, 1, 2, 1, 0); settle(); adv();
    set_id(1, 2, 2, 1, 1, 1, 3, 0, 0); settle();
    check_eq("lu_pc_write",    32'(pc_write), 0);
    check_eq("lu_ifid_write",  32'(ifid_write), 0);
    check_eq("lu_idex_bubble", 32'(idex_bubble), 1);
    check_eq("lu_ifid_flush",  32'(ifid_flush), 0);
    adv();
    settle();
    check_eq("lu_one_cycle_pc",  32'(pc_write), 1);
    check_eq("lu_one_cycle_bub", 32'(idex_bubble), 0);
    adv();
    nop(); settle();
    check_eq("lu_fwd_a", 32'(fwd_a), 1);
    check_eq("lu_fwd_b", 32'(fwd_b), 1);
    drain();
    settle();
    check_eq("lu_stall_cnt", stall_cnt, exp_cnt(1));

    // lw $0 ; add $3,$0,$0 : register 0 never hazards nor forwards
    adv();
    set_id(1, 1, 0, 1, 0, 1, 0, 1, 0); settle(); adv();
    set_id(1, 0, 0, 1, 1, 1, 3, 0, 0); settle();
    check_eq("r0_no_stall", 32'(pc_write), 1);
    check_eq("r0_no_bubble", 32'(idex_bubble), 0);
    adv();
    nop(); settle();
    check_eq("r0_fwd_a", 32'(fwd_a), 0);
    check_eq("r0_fwd_b", 32'(fwd_b), 0);
    drain();

    // addi $1 ; mul $5,$1,$2 ; add $6,$5,$0
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 0); settle(); adv();
    set_id(1, 1, 2, 1, 1, 1, 5, 0, 1); settle();
    check_eq("mul_enter_pc", 32'(pc_write), 1);
    adv();
    set_id(1, 5, 0, 1, 0, 1, 6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("mul_busy%0d", i),     32'(ex_busy), 1);
      check_eq($sformatf("mul_pc%0d", i),       32'(pc_write), 0);
      check_eq($sformatf("mul_ifid_wr%0d", i),  32'(ifid_write), 0);
      check_eq($sformatf("mul_exmem_bub%0d", i), 32'(exmem_bubble), 1);
      check_eq($sformatf("mul_fwd_a%0d", i),    32'(fwd_a), 0);
      adv();
    end
    settle();
    check_eq("mul_done_busy", 32'(ex_busy), 0);
    check_eq("mul_done_pc",   32'(pc_write), 1);
    check_eq("mul_done_bub",  32'(exmem_bubble), 0);
    adv();
    nop(); settle();
    check_eq("mul_dep_fwd_a", 32'(fwd_a), 2);
    drain();

    // branch taken while ID holds a load-use hazard
    set_id(1, 1, 0, 1, 0, 1, 7, 1, 0); settle(); adv();
    set_id(1, 7, 0, 1, 0, 1, 8, 0, 0);
    ex_br_taken = 1'b1;
    settle();
    check_eq("br_ifid_flush",  32'(ifid_flush), 1);
    check_eq("br_idex_bubble", 32'(idex_bubble), 1);
    check_eq("br_pc_write",    32'(pc_write), 1);
    adv();
    ex_br_taken = 1'b0;
    nop(); settle();
    check_eq("br_stall_cnt", stall_cnt, exp_cnt(4));
    check_eq("br_flush_cnt", flush_cnt, exp_cnt(1));
    drain();

    // reset during the second busy cycle of a multiply
    set_id(1, 1, 2, 1, 1, 1, 5, 0, 1); settle(); adv();
    nop(); settle();
    check_eq("rmul_busy1", 32'(ex_busy), 1);
    adv();
    settle();
    check_eq("rmul_busy2", 32'(ex_busy), 1);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    settle();
    check_eq("rmul_ex_busy",   32'(ex_busy), 0);
    check_eq("rmul_pc_write",  32'(pc_write), 1);
    check_eq("rmul_fwd_a",     32'(fwd_a), 0);
    check_eq("rmul_fwd_b",     32'(fwd_b), 0);
    check_eq("rmul_stall_cnt", stall_cnt, 0);
    check_eq("rmul_flush_cnt", flush_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Replaces the split combinational hazard-detection and forwarding units.
- Tracks every in-flight destination register itself with a shadow shift register (EX, MEM, WB slots), so the datapath only presents ID-stage decode info and the EX branch result.
- Adds what the previous pair lacked: taken-branch flush, a multi-cycle multiply occupying EX, and a parametrised register-address width.

Parameters:
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- MUL_LAT, 4, total EX cycles of a multiply (≥1; 1 means no stall).
- CNT_W, 32, perf counter width (only with HAZ_PERF_CNT_EN).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW each  ID source addresses
- id_use_rs, id_use_rt  in  1 each  source actually read
- id_wr_en  in  1  ID instruction writes a register
- id_wr_addr  in  REG_AW  destination (already Reg_dst-muxed)
- id_is_load  in  1  ID instruction is a load
- id_is_mul  in  1  ID instruction is a multiply
- ex_br_taken  in  1  EX-stage branch resolved taken
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_bubble  out  1  load control-zeroes into ID/EX
- exmem_bubble  out  1  load control-zeroes into EX/MEM
- fwd_a, fwd_b  out  2 each  EX operand select: 00 RF, 01 MEM/WB, 10 EX/MEM
- ex_busy  out  1  multiply still occupying EX
- stall_cnt, flush_cnt  out  CNT_W each  perf counters

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Internal state:
  - Slots EX, MEM, WB, each {valid, wr_en, wr_addr, is_load}.
  - EX slot additionally stores rs, rt, use_rs, use_rt, is_mul.
  - mul_cnt, width clog2(MUL_LAT)+1.
- Reset:
  - All slots invalid, mul_cnt=0.
  - Outputs after reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, exmem_bubble=0, fwd_a=fwd_b=00, ex_busy=0, counters=0.
- All outputs are combinational from the slots plus ID/EX inputs; zero added latency.
- A slot "writes r" iff valid & wr_en & wr_addr==r & r!=0.
- Forwarding, for the EX slot only:
  - fwd_a=10 if the MEM slot writes ex.rs & use_rs; else 01 if the WB slot writes it; else 00.
  - fwd_b is the same using rt.
  - MEM has priority over WB.
  - Forced to 00 while ex_busy; the datapath latches operands on the first EX cycle.
- Priority per cycle: busy > branch > load-use > normal.
  1. Busy: EX slot is_mul and mul_cnt < MUL_LAT-1.
     - ex_busy=1, pc_write=0, ifid_write=0, exmem_bubble=1.
     - EX slot holds; MEM←invalid; WB←MEM; mul_cnt++.
     - ex_br_taken ignored.
  2. Branch: ex_br_taken=1.
     - ifid_flush=1, idex_bubble=1, pc_write=1.
     - EX←invalid (ID instruction squashed); slots shift.
  3. Load-use: EX slot is_load & id_valid & (EX writes id_rs with id_use_rs, or EX writes id_rt with id_use_rt).
     - pc_write=0, ifid_write=0, idex_bubble=1.
     - EX←invalid; slots shift.
     - Exactly one stall cycle; the following cycle forwards 01.
  4. Normal: shift EX←ID decode (valid=id_valid), MEM←EX, WB←MEM; mul_cnt←0.
- Multiply timing: on EX entry mul_cnt=0. The instruction spends exactly MUL_LAT cycles in EX with MUL_LAT-1 busy cycles, then advances normally.
- Consumers of a multiply result forward from MEM as usual; no extra stall.
- WB-to-ID same-cycle hazard is out of scope; the RF is write-through.
- rst mid-multiply aborts it: slots invalid, mul_cnt=0, ex_busy=0 next cycle.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each load-use or busy cycle.
  - flush_cnt increments on each branch flush.
  - Both wrap modulo 2^CNT_W and clear on rst.
- Undefined: both outputs tied to 0, no counter flops.

Decomposition:
- Package pipe_pkg holds:
  - localparams FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The hazard-slot struct typedef {valid, wr_en, wr_addr, is_load}.
  - Default REG_AW.
- One natural sub-module: fwd_select, the combinational priority compare of one source address against MEM/WB slots, instantiated twice (a, b).

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 → second instruction in EX: fwd_a=10; with one nop between: fwd_a=01; never any stall.
- lw $2,0($1) then add $3,$2,$2 → one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle fwd_a=fwd_b=01.
- lw $0,.. then add $3,$0,$0 → no stall, fwd 00; write to $0 never forwards.
- mul with MUL_LAT=4 → ex_busy=1 for 3 consecutive cycles, exmem_bubble=1, PC frozen; 4th cycle advances; dependent add gets fwd_a=10.
- ex_br_taken=1 while ID holds a load-use hazard → ifid_flush=1, idex_bubble=1, pc_write=1 (branch wins); stall_cnt unchanged, flush_cnt +1.
- rst asserted on the 2nd busy cycle of a mul → next cycle ex_busy=0, pc_write=1, fwd 00, counters 0.
